// File: rtl/shift_add_mul_pkg.sv
// Shared ALU package: FSM state encodings and the common ALU operand width.
package shift_add_mul_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_add_mul_step.sv
// One shift-add step of the sequential multiplier:
// acc_next = acc + (bit ? a << shamt : 0), computed at 2*WIDTH bits.
module shift_add_step
  import shift_add_mul_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic               bit_i,
  input  logic [CW-1:0]      shamt_i,
  output logic [2*WIDTH-1:0] acc_next_o
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] addend;

  assign a_ext  = {{WIDTH{1'b0}}, a_i};
  assign addend = bit_i ? (a_ext << shamt_i) : '0;

  assign acc_next_o = acc_i + addend;

endmodule

// File: rtl/shift_add_mul.sv
// Sequential unsigned multiplier, one multiplier bit per cycle,
// with start/busy/done handshake and a registered product.
module shift_add_mul
  import shift_add_mul_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               zero
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic             zero_q, zero_d;
  logic [PW-1:0]    step;

  shift_add_step #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_step (
    .acc_i      (acc_q),
    .a_i        (a_q),
    .bit_i      (b_q[cnt_q]),
    .shamt_i    (cnt_q),
    .acc_next_o (step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    zero_d  = zero_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = step;
        cnt_d = cnt_q + CW'(1);
        // Last step bypasses acc so the product lands on the same edge.
        if (cnt_q == CNT_LAST) begin
          prod_d  = step;
          zero_d  = (step == '0);
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign product = prod_q;
  assign zero    = zero_q;

endmodule
